mem_arbiter: RTL and testbench

Sequential arbiter sharing one single-ported unified memory between the instruction-fetch port and the data-memory port of the 5-stage pipelined core. Requests are serialized through a three-state FSM, and each access is forwarded to a memory whose latency is variable. The block produces per-port stall signals for the hazard unit. A watchdog aborts any access whose memory acknowledge never arrives.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/arb_watchdog.sv | 36 +++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// =============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and access-mode constants for the memory arbiter.
// Revision : 1.0 - initial release
// =============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_DM = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_t;

    // funct3 load/store width encodings
    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// =============================================================================
// Module   : arb_watchdog
// Purpose  : Saturating wait counter; expire flags an access stuck TIMEOUT cycles.
// Revision : 1.0 - initial release
// =============================================================================
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int              CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   c_limit = CW'(TIMEOUT);

    logic [CW-1:0] r_count;

    // Saturates at the limit so a stale count cannot wrap while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_limit)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign expire = (r_count == c_limit);

endmodule : arb_watchdog
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-ported memory between fetch and data ports with
//            alternating fairness, per-port stalls and an access watchdog.
// Revision : 1.0 - initial release
// =============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_ready,
    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [2:0]       dm_mode,
    input  logic [WIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0] dm_wdata,
    output logic [WIDTH-1:0] dm_rdata,
    output logic             dm_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic [2:0]       mem_mode,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             stall_if,
    output logic             stall_mem,
    output logic             err
);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    grant_t           r_last_grant;
    logic             r_mem_we;
    logic [2:0]       r_mem_mode;
    logic [WIDTH-1:0] r_mem_addr;
    logic [WIDTH-1:0] r_mem_wdata;
    logic             r_err;

    logic             w_grant_if;
    logic             w_grant_dm;
    logic             w_serving;
    logic             w_expire;
    logic             w_done;
    logic             w_timeout;
    logic [WIDTH-1:0] w_rdata;

    assign w_serving = (r_state == SERVE_IF) || (r_state == SERVE_DM);
    // A real acknowledge wins over a simultaneous watchdog expiry.
    assign w_done    = w_serving && (mem_ack || w_expire);
    assign w_timeout = w_serving && !mem_ack && w_expire;
    assign w_rdata   = (mem_ack && !r_mem_we) ? mem_rdata : '0;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_grant_if || w_grant_dm),
        .enable (w_serving && !mem_ack),
        .expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_if   = 1'b0;
        w_grant_dm   = 1'b0;
        case (r_state)
            IDLE: begin
                // Data port wins a tie unless it was the last one served.
                if (dm_req && (!if_req || (r_last_grant == GNT_IF))) begin
                    w_grant_dm   = 1'b1;
                    w_next_state = SERVE_DM;
                end else if (if_req) begin
                    w_grant_if   = 1'b1;
                    w_next_state = SERVE_IF;
                end
            end
            SERVE_IF, SERVE_DM: begin
                if (w_done) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req   = w_serving;
        if_ready  = (r_state == SERVE_IF) && w_done && !rst;
        dm_ready  = (r_state == SERVE_DM) && w_done && !rst;
        if_rdata  = (r_state == SERVE_IF) ? w_rdata : '0;
        dm_rdata  = (r_state == SERVE_DM) ? w_rdata : '0;
        stall_if  = if_req && !if_ready;
        stall_mem = dm_req && !dm_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= GNT_IF;
            r_mem_we     <= 1'b0;
            r_mem_mode   <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_grant_dm) begin
                r_last_grant <= GNT_DM;
                r_mem_we     <= dm_we;
                r_mem_mode   <= dm_mode;
                r_mem_addr   <= dm_addr;
                r_mem_wdata  <= dm_wdata;
            end else if (w_grant_if) begin
                r_last_grant <= GNT_IF;
                r_mem_we     <= 1'b0;
                r_mem_mode   <= MODE_W;
                r_mem_addr   <= if_addr;
                r_mem_wdata  <= '0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_mode  = r_mem_mode;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed and randomized transaction checks for mem_arbiter.
// Revision : 1.0 - initial release
// =============================================================================
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int W  = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [W-1:0]  if_addr;
    logic [W-1:0]  if_rdata;
    logic          if_ready;
    logic          dm_req;
    logic          dm_we;
    logic [2:0]    dm_mode;
    logic [W-1:0]  dm_addr;
    logic [W-1:0]  dm_wdata;
    logic [W-1:0]  dm_rdata;
    logic          dm_ready;
    logic          mem_req;
    logic          mem_we;
    logic [2:0]    mem_mode;
    logic [W-1:0]  mem_addr;
    logic [W-1:0]  mem_wdata;
    logic          mem_ack;
    logic [W-1:0]  mem_rdata;
    logic          stall_if;
    logic          stall_mem;
    logic          err;

    int vectors     = 0;
    int miscompares = 0;
    bit m_last_dm;
    bit m_err;
    logic [2:0] modes [5] = '{MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU};

    mem_arbiter #(
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_mode   (dm_mode),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_mode  (mem_mode),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Fairness rule: a tie goes to DM unless DM was served last.
    function automatic bit pick_dm(bit ir, bit dr, bit last_dm);
        if (ir && dr) return !last_dm;
        return dr;
    endfunction

    task automatic do_reset();
        rst     = 1'b1;
        if_req  = 1'b0;
        dm_req  = 1'b0;
        mem_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        m_last_dm = 1'b0;
        m_err     = 1'b0;
    endtask

    // Called at posedge+1 of an IDLE cycle with requests already driven.
    // lat = SERVE cycle index carrying mem_ack, or -1 for no acknowledge.
    task automatic serve(input bit p_dm, input int lat, input logic [31:0] rd);
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        e_we;
        logic [2:0]  e_mode;
        bit          ack;
        bit          tmo;
        bit          done;
        e_addr  = p_dm ? dm_addr : if_addr;
        e_we    = p_dm ? dm_we : 1'b0;
        e_mode  = p_dm ? dm_mode : MODE_W;
        e_wdata = dm_wdata;
        @(negedge clk);
        chk("grant_mem_req", 32'(mem_req), 32'd0);
        chk("grant_if_ready", 32'(if_ready), 32'd0);
        chk("grant_dm_ready", 32'(dm_ready), 32'd0);
        chk("grant_stall_if", 32'(stall_if), 32'(if_req));
        chk("grant_stall_mem", 32'(stall_mem), 32'(dm_req));
        @(posedge clk);
        #1;
        m_last_dm = p_dm;
        for (int k = 0; k <= TO; k++) begin
            ack       = (k == lat);
            tmo       = !ack && (k == TO);
            done      = ack || tmo;
            e_rdata   = (ack && !e_we) ? rd : 32'd0;
            mem_ack   = ack;
            mem_rdata = ack ? rd : $urandom;
            @(negedge clk);
            chk("mem_req", 32'(mem_req), 32'd1);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_mode", 32'(mem_mode), 32'(e_mode));
            if (p_dm) chk("mem_wdata", mem_wdata, e_wdata);
            chk("if_ready", 32'(if_ready), 32'(!p_dm && done));
            chk("dm_ready", 32'(dm_ready), 32'(p_dm && done));
            if (done) chk(p_dm ? "dm_rdata" : "if_rdata", p_dm ? dm_rdata : if_rdata, e_rdata);
            chk("stall_if", 32'(stall_if), 32'(if_req && !(!p_dm && done)));
            chk("stall_mem", 32'(stall_mem), 32'(dm_req && !(p_dm && done)));
            chk("err", 32'(err), 32'(m_err));
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (tmo) m_err = 1'b1;
            if (done) begin
                if (p_dm) dm_req = 1'b0;
                else      if_req = 1'b0;
                break;
            end
        end
    endtask

    task automatic set_dm(input logic we, input logic [2:0] mode, input logic [31:0] a, input logic [31:0] d);
        dm_req   = 1'b1;
        dm_we    = we;
        dm_mode  = mode;
        dm_addr  = a;
        dm_wdata = d;
    endtask

    initial begin
        int lat;
        bit p;
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_mode   = '0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        do_reset();

        // Reset state, and IDLE holds with no requests
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_mem_mode", 32'(mem_mode), 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
            chk("rst_readies", 32'({if_ready, dm_ready}), 32'd0);
            chk("rst_stalls", 32'({stall_if, stall_mem}), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            @(posedge clk);
            #1;
        end

        // Single fetch, acknowledged in the first request cycle
        if_req  = 1'b1;
        if_addr = 32'h0000_0004;
        serve(1'b0, 0, 32'h0050_0093);

        // Simultaneous requests from reset: DM first, then IF; a fresh tie after DM goes to IF
        do_reset();
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        set_dm(1'b0, MODE_W, 32'h0000_1000, 32'h0);
        serve(1'b1, 1, 32'h1111_2222);
        set_dm(1'b0, MODE_H, 32'h0000_1004, 32'h0);
        serve(1'b0, 0, 32'h3333_4444);
        serve(1'b1, 2, 32'h5555_6666);

        // Store passthrough
        set_dm(1'b1, MODE_B, 32'h0001_0003, 32'hDEAD_BEEF);
        serve(1'b1, 2, 32'hCAFE_F00D);

        // Variable latency and the ack-at-limit boundary
        set_dm(1'b0, MODE_W, 32'h0000_2000, 32'h0);
        serve(1'b1, 7, 32'h0BAD_F00D);
        set_dm(1'b0, MODE_BU, 32'h0000_2001, 32'h0);
        serve(1'b1, TO, 32'h0000_00A5);

        // Timeout, then err stays sticky through a successful access
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        serve(1'b0, -1, 32'h1234_5678);
        set_dm(1'b0, MODE_HU, 32'h0000_3002, 32'h0);
        serve(1'b1, 0, 32'h0000_BEEF);

        // Reset during the second cycle of a data access
        set_dm(1'b0, MODE_W, 32'h0000_4000, 32'h0);
        @(negedge clk);
        chk("rma_grant_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rma_serve_mem_req", 32'(mem_req), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rma_rst_dm_ready", 32'(dm_ready), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        dm_req    = 1'b0;
        m_last_dm = 1'b0;
        m_err     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        @(negedge clk);
        chk("rma_mem_req", 32'(mem_req), 32'd0);
        chk("rma_late_ack_dm_ready", 32'(dm_ready), 32'd0);
        chk("rma_late_ack_if_ready", 32'(if_ready), 32'd0);
        chk("rma_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("rma_idle_mem_req", 32'(mem_req), 32'd0);
        chk("rma_mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        #1;

        // Randomized traffic against the transaction model
        for (int t = 0; t < 60; t++) begin
            if (!if_req && ($urandom_range(0, 1) == 1)) begin
                if_req  = 1'b1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dm_req && ($urandom_range(0, 1) == 1)) begin
                set_dm(1'($urandom_range(0, 1)), modes[$urandom_range(0, 4)], $urandom, $urandom);
            end
            if (!if_req && !dm_req) begin
                if_req  = 1'b1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
            p   = pick_dm(if_req, dm_req, m_last_dm);
            serve(p, lat, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
